// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue pipeline register feeding the 64-bit LEGv8 ALU.
// Decodes one instruction per transfer and resolves EX/MEM and MEM/WB forwarding.
// It then captures the ALU operands and control bits into a single-entry register
// with a valid/ready handshake, stall (i_ex_ready low) and flush.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_in_valid / o_in_ready  upstream handshake
//   i_instr                  instruction word
//   i_rn/rm/rt_data          register-file reads for instr[9:5] / [20:16] / [4:0]
//   i_exmem_*, i_memwb_*     forwarding sources (write enable, index, value)
//   i_ex_ready               EX consumes the held entry this cycle
//   i_flush                  kill the held entry and the incoming transfer
//   o_out_valid              held entry valid
//   o_a, o_b                 ALU operands
//   o_alu_op, o_shamt        ALU operation and shift amount
//   o_store_data             forwarded Rt value
//   o_rd                     destination index
//   o_reg_write, o_mem_read, o_mem_write, o_cbz, o_illegal   control bits
module id_ex_stage #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [31:0]   i_instr,
  input  logic [DW-1:0] i_rn_data,
  input  logic [DW-1:0] i_rm_data,
  input  logic [DW-1:0] i_rt_data,
  input  logic          i_exmem_wen,
  input  logic          i_memwb_wen,
  input  logic [4:0]    i_exmem_rd,
  input  logic [4:0]    i_memwb_rd,
  input  logic [DW-1:0] i_exmem_data,
  input  logic [DW-1:0] i_memwb_data,
  input  logic          i_ex_ready,
  input  logic          i_flush,
  output logic          o_out_valid,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [3:0]    o_alu_op,
  output logic [5:0]    o_shamt,
  output logic [DW-1:0] o_store_data,
  output logic [4:0]    o_rd,
  output logic          o_reg_write,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic          o_cbz,
  output logic          o_illegal
);

  // XZR reads as zero; EX/MEM is younger than MEM/WB so it wins.
  function automatic logic [DW-1:0] f_resolve(
    input logic [4:0]    idx,
    input logic [DW-1:0] raw,
    input logic          ex_wen,
    input logic [4:0]    ex_rd,
    input logic [DW-1:0] ex_data,
    input logic          wb_wen,
    input logic [4:0]    wb_rd,
    input logic [DW-1:0] wb_data
  );
    if (idx == 5'd31)                 return '0;
    else if (ex_wen && ex_rd == idx)  return ex_data;
    else if (wb_wen && wb_rd == idx)  return wb_data;
    else                              return raw;
  endfunction

  logic [DW-1:0] w_rn_res, w_rm_res, w_rt_res;
  logic [DW-1:0] w_b, w_imm12, w_imm9;
  logic [3:0]    w_alu_op;
  logic [5:0]    w_shamt;
  logic [4:0]    w_rd;
  logic          w_reg_write, w_mem_read, w_mem_write, w_cbz, w_illegal;
  logic          w_transfer;

  logic          r_out_valid;
  logic [DW-1:0] r_a, r_b, r_store_data;
  logic [3:0]    r_alu_op;
  logic [5:0]    r_shamt;
  logic [4:0]    r_rd;
  logic          r_reg_write, r_mem_read, r_mem_write, r_cbz, r_illegal;

  assign w_rn_res = f_resolve(i_instr[9:5], i_rn_data, i_exmem_wen, i_exmem_rd, i_exmem_data,
                              i_memwb_wen, i_memwb_rd, i_memwb_data);
  assign w_rm_res = f_resolve(i_instr[20:16], i_rm_data, i_exmem_wen, i_exmem_rd, i_exmem_data,
                              i_memwb_wen, i_memwb_rd, i_memwb_data);
  assign w_rt_res = f_resolve(i_instr[4:0], i_rt_data, i_exmem_wen, i_exmem_rd, i_exmem_data,
                              i_memwb_wen, i_memwb_rd, i_memwb_data);

  assign w_imm12 = {{(DW-12){1'b0}}, i_instr[21:10]};
  assign w_imm9  = {{(DW-9){i_instr[20]}}, i_instr[20:12]};

  always_comb begin
    w_b         = '0;
    w_alu_op    = 4'd15;
    w_shamt     = 6'd0;
    w_rd        = i_instr[4:0];
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_cbz       = 1'b0;
    w_illegal   = 1'b0;
    casez (i_instr[31:21])
      11'b10110100???: begin  // CBZ
        w_b   = w_rt_res;
        w_cbz = 1'b1;
        w_rd  = 5'd0;
      end
      11'b1001000100?: begin  // ADDI
        w_b = w_imm12; w_alu_op = 4'd0; w_reg_write = 1'b1;
      end
      11'b1101000100?: begin  // SUBI
        w_b = w_imm12; w_alu_op = 4'd1; w_reg_write = 1'b1;
      end
      11'b10001011000: begin w_b = w_rm_res; w_alu_op = 4'd0; w_reg_write = 1'b1; end
      11'b11001011000: begin w_b = w_rm_res; w_alu_op = 4'd1; w_reg_write = 1'b1; end
      11'b10001010000: begin w_b = w_rm_res; w_alu_op = 4'd2; w_reg_write = 1'b1; end
      11'b10101010000: begin w_b = w_rm_res; w_alu_op = 4'd3; w_reg_write = 1'b1; end
      11'b11001010000: begin w_b = w_rm_res; w_alu_op = 4'd4; w_reg_write = 1'b1; end
      11'b11010011011: begin w_alu_op = 4'd6; w_shamt = i_instr[15:10]; w_reg_write = 1'b1; end
      11'b11010011010: begin w_alu_op = 4'd7; w_shamt = i_instr[15:10]; w_reg_write = 1'b1; end
      11'b11111000010: begin  // LDUR
        w_b = w_imm9; w_alu_op = 4'd0; w_mem_read = 1'b1; w_reg_write = 1'b1;
      end
      11'b11111000000: begin  // STUR
        w_b = w_imm9; w_alu_op = 4'd0; w_mem_write = 1'b1; w_rd = 5'd0;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_in_ready = !i_flush && (!r_out_valid || i_ex_ready);
  assign w_transfer = i_in_valid && o_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
    end else if (i_ex_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Payload only moves on a transfer, so a stalled entry keeps its captured forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_alu_op     <= 4'd0;
      r_shamt      <= 6'd0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_cbz        <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_transfer) begin
      r_a          <= w_rn_res;
      r_b          <= w_b;
      r_store_data <= w_rt_res;
      r_alu_op     <= w_alu_op;
      r_shamt      <= w_shamt;
      r_rd         <= w_rd;
      r_reg_write  <= w_reg_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_cbz        <= w_cbz;
      r_illegal    <= w_illegal;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_store_data = r_store_data;
  assign o_alu_op     = r_alu_op;
  assign o_shamt      = r_shamt;
  assign o_rd         = r_rd;
  assign o_reg_write  = r_reg_write;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_cbz        = r_cbz;
  assign o_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of decode/forwarding vectors applied
// back-to-back, then hand-written stall, flush, drain and reset-mid-stall sequences.
module tb_id_ex_stage;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [31:0]   instr = '0;
  logic [DW-1:0] rn_data = '0, rm_data = '0, rt_data = '0;
  logic          exmem_wen = 1'b0, memwb_wen = 1'b0;
  logic [4:0]    exmem_rd = '0, memwb_rd = '0;
  logic [DW-1:0] exmem_data = '0, memwb_data = '0;
  logic          ex_ready = 1'b1, flush = 1'b0;
  logic          out_valid;
  logic [DW-1:0] a, b, store_data;
  logic [3:0]    alu_op;
  logic [5:0]    shamt;
  logic [4:0]    rd;
  logic          reg_write, mem_read, mem_write, cbz, illegal;

  int n_vec = 0;
  int n_bad = 0;

  id_ex_stage #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_instr(instr), .i_rn_data(rn_data), .i_rm_data(rm_data), .i_rt_data(rt_data),
    .i_exmem_wen(exmem_wen), .i_memwb_wen(memwb_wen), .i_exmem_rd(exmem_rd),
    .i_memwb_rd(memwb_rd), .i_exmem_data(exmem_data), .i_memwb_data(memwb_data),
    .i_ex_ready(ex_ready), .i_flush(flush), .o_out_valid(out_valid), .o_a(a), .o_b(b),
    .o_alu_op(alu_op), .o_shamt(shamt), .o_store_data(store_data), .o_rd(rd),
    .o_reg_write(reg_write), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_cbz(cbz), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [31:0]   instr;
    logic [DW-1:0] rn, rm, rt;
    logic          ew;
    logic [4:0]    erd;
    logic [DW-1:0] ed;
    logic          mw;
    logic [4:0]    mrd;
    logic [DW-1:0] md;
    logic [DW-1:0] ea, eb, es;
    logic [3:0]    eop;
    logic [5:0]    esh;
    logic [4:0]    erdo;
    logic [4:0]    ectl;  // {reg_write, mem_read, mem_write, cbz, illegal}
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] mk_r(input logic [10:0] op, input logic [4:0] rm_i,
                                       input logic [5:0] sh, input logic [4:0] rn_i,
                                       input logic [4:0] rd_i);
    return {op, rm_i, sh, rn_i, rd_i};
  endfunction

  task automatic add_vec(input string nm, input logic [31:0] ins,
                         input logic [DW-1:0] rn, input logic [DW-1:0] rm,
                         input logic [DW-1:0] rt, input logic ew, input logic [4:0] erd,
                         input logic [DW-1:0] ed, input logic mw, input logic [4:0] mrd,
                         input logic [DW-1:0] md, input logic [DW-1:0] ea,
                         input logic [DW-1:0] eb, input logic [DW-1:0] es,
                         input logic [3:0] eop, input logic [5:0] esh,
                         input logic [4:0] erdo, input logic [4:0] ectl);
    vec_t v;
    v.name = nm; v.instr = ins; v.rn = rn; v.rm = rm; v.rt = rt;
    v.ew = ew; v.erd = erd; v.ed = ed; v.mw = mw; v.mrd = mrd; v.md = md;
    v.ea = ea; v.eb = eb; v.es = es; v.eop = eop; v.esh = esh; v.erdo = erdo; v.ectl = ectl;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic ev, input logic [DW-1:0] ea,
                          input logic [DW-1:0] eb, input logic [DW-1:0] es,
                          input logic [3:0] eop, input logic [5:0] esh,
                          input logic [4:0] erdo, input logic [4:0] ectl);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({nm, ".a"}, a, ea);
    chk({nm, ".b"}, b, eb);
    chk({nm, ".store_data"}, store_data, es);
    chk({nm, ".alu_op"}, 64'(alu_op), 64'(eop));
    chk({nm, ".shamt"}, 64'(shamt), 64'(esh));
    chk({nm, ".rd"}, 64'(rd), 64'(erdo));
    chk({nm, ".ctl"}, 64'({reg_write, mem_read, mem_write, cbz, illegal}), 64'(ectl));
  endtask

  task automatic drive(input vec_t v);
    instr = v.instr; rn_data = v.rn; rm_data = v.rm; rt_data = v.rt;
    exmem_wen = v.ew; exmem_rd = v.erd; exmem_data = v.ed;
    memwb_wen = v.mw; memwb_rd = v.mrd; memwb_data = v.md;
  endtask

  logic [31:0] i_add, i_subi;

  initial begin
    i_add  = mk_r(11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3);
    i_subi = {10'b1101000100, 12'hFFF, 5'd1, 5'd4};

    // name, instr, rn, rm, rt, ew, erd, ed, mw, mrd, md, A, B, store, op, shamt, rd, ctl
    add_vec("add", i_add, 5, 7, 0, 0, 0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 3, 5'b10000);
    add_vec("subi", i_subi, 100, 0, 0, 0, 0, 0, 0, 0, 0, 100, 64'hFFF, 0, 1, 0, 4, 5'b10000);
    add_vec("ldur", {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2}, 64'h1000, 0, 0,
            0, 0, 0, 0, 0, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 2, 5'b11000);
    add_vec("lsr", mk_r(11'b11010011010, 5'd0, 6'd63, 5'd1, 5'd5), 64'h8000_0000_0000_0000,
            0, 0, 0, 0, 0, 0, 0, 0, 64'h8000_0000_0000_0000, 0, 0, 7, 63, 5, 5'b10000);
    add_vec("fwd_both", mk_r(11'b10001011000, 5'd1, 6'd0, 5'd1, 5'd3), 99, 99, 0,
            1, 1, 10, 1, 1, 20, 10, 10, 0, 0, 0, 3, 5'b10000);
    add_vec("fwd_memwb", i_add, 5, 7, 0, 1, 5, 10, 1, 2, 20, 5, 20, 0, 0, 0, 3, 5'b10000);
    add_vec("fwd_off", i_add, 5, 7, 0, 0, 1, 10, 0, 2, 20, 5, 7, 0, 0, 0, 3, 5'b10000);
    add_vec("xzr", mk_r(11'b10001011000, 5'd2, 6'd0, 5'd31, 5'd3), 123, 7, 0,
            1, 31, 10, 0, 0, 0, 0, 7, 0, 0, 0, 3, 5'b10000);
    add_vec("stur", {11'b11111000000, 9'd16, 2'b00, 5'd2, 5'd6}, 64'h200, 0, 64'h77,
            1, 6, 64'h55, 0, 0, 0, 64'h200, 16, 64'h55, 0, 0, 0, 5'b00100);
    add_vec("cbz", {8'b10110100, 19'd5, 5'd7}, 64'hAB, 0, 64'h33,
            0, 0, 0, 0, 0, 0, 64'hAB, 64'h33, 64'h33, 15, 0, 0, 5'b00010);
    add_vec("illegal", 32'h0, 64'h11, 0, 64'h22, 0, 0, 0, 0, 0, 0,
            64'h11, 0, 64'h22, 15, 0, 0, 5'b00001);
    add_vec("eor", mk_r(11'b11001010000, 5'd3, 6'd0, 5'd2, 5'd1), 64'hF0, 64'hFF, 0,
            0, 0, 0, 0, 0, 0, 64'hF0, 64'hFF, 0, 4, 0, 1, 5'b10000);
    add_vec("lsl", mk_r(11'b11010011011, 5'd0, 6'd4, 5'd8, 5'd9), 3, 0, 0,
            0, 0, 0, 0, 0, 0, 3, 0, 0, 6, 4, 9, 5'b10000);
    add_vec("addi", {10'b1001000100, 12'd1, 5'd11, 5'd10}, 41, 0, 0,
            0, 0, 0, 0, 0, 0, 41, 1, 0, 0, 0, 10, 5'b10000);
    add_vec("and", mk_r(11'b10001010000, 5'd2, 6'd0, 5'd1, 5'd3), 64'hC, 64'hA, 0,
            0, 0, 0, 0, 0, 0, 64'hC, 64'hA, 0, 2, 0, 3, 5'b10000);
    add_vec("orr", mk_r(11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd3), 64'hC, 64'hA, 0,
            0, 0, 0, 0, 0, 0, 64'hC, 64'hA, 0, 3, 0, 3, 5'b10000);

    // Reset with stale inputs present.
    drive(vq[0]);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 5'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("reset.in_ready", 64'(in_ready), 1);
    chk_outs("post_reset", 0, 0, 0, 0, 0, 0, 0, 5'b0);

    // Back-to-back table with ex_ready held high.
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      in_valid = 1'b1;
      ex_ready = 1'b1;
      #1 chk({vq[i].name, ".in_ready"}, 64'(in_ready), 1);
      @(posedge clk);
      #1 chk_outs(vq[i].name, 1, vq[i].ea, vq[i].eb, vq[i].es, vq[i].eop, vq[i].esh,
                  vq[i].erdo, vq[i].ectl);
    end

    // Stall: held ADD must not change or re-forward while SUBI waits upstream.
    @(negedge clk);
    drive(vq[0]);
    @(posedge clk);
    @(negedge clk);
    ex_ready = 1'b0;
    instr = i_subi; rn_data = 100;
    exmem_wen = 1'b1; exmem_rd = 5'd1; exmem_data = 999;
    #1 chk("stall.in_ready", 64'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 chk_outs("stall", 1, 5, 7, 0, 0, 0, 3, 5'b10000);
    end
    @(negedge clk);
    exmem_wen = 1'b0;
    ex_ready = 1'b1;
    #1 chk("release.in_ready", 64'(in_ready), 1);
    @(posedge clk);
    #1 chk_outs("release", 1, 100, 64'hFFF, 0, 1, 0, 4, 5'b10000);

    // Flush while holding SUBI with ADD offered: entry dies, ADD is dropped.
    @(negedge clk);
    ex_ready = 1'b0;
    flush = 1'b1;
    drive(vq[0]);
    #1 chk("flush.in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1 chk_outs("flush", 0, 100, 64'hFFF, 0, 1, 0, 4, 5'b10000);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("post_flush.out_valid", 64'(out_valid), 0);

    // Unknown opcode 0x0 through the handshake.
    @(negedge clk);
    drive(vq[10]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 chk_outs("illegal_seq", 1, 64'h11, 0, 64'h22, 15, 0, 0, 5'b00001);

    // Drain with no new transfer: valid drops, payload holds.
    @(negedge clk);
    in_valid = 1'b0;
    ex_ready = 1'b1;
    @(posedge clk);
    #1 chk_outs("drain", 0, 64'h11, 0, 64'h22, 15, 0, 0, 5'b00001);

    // Reset asserted mid-stall clears the held entry immediately.
    @(negedge clk);
    drive(vq[1]);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ex_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_outs("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 5'b0);
    @(posedge clk);
    #1 chk_outs("reset_held", 0, 0, 0, 0, 0, 0, 0, 5'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("reset_mid.in_ready", 64'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
